prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/prefetch_queue_pkg.sv | 19 +
 rtl/prefetch_queue_fifo.sv | 84 ++++++++
 rtl/prefetch_queue.sv | 145 ++++++++++++++
 tb/tb_prefetch_queue.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: reset vector,
// default depth, bus-owner encoding and the segment:offset address helper.
package prefetch_queue_pkg;

  localparam int          DEPTH_DEFAULT = 6;
  localparam logic [15:0] RESET_CS      = 16'hFFFF;
  localparam logic [15:0] RESET_IP      = 16'h0000;

  typedef enum logic [1:0] {
    OWN_IDLE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } bus_owner_e;

  function automatic logic [19:0] linear_addr(input logic [15:0] seg, input logic [15:0] off);
    return {seg, 4'h0} + {4'h0, off};
  endfunction

endpackage

// File: rtl/prefetch_queue_fifo.sv
// Circular byte queue holding {ip, byte} entries; depth need not be a power of two.
module prefetch_fifo
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [23:0]   wdata,
  output logic [23:0]   rdata,
  output logic [CW-1:0] count
);

  logic [23:0]   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // next pointer/count state; a push into a full queue is only accepted alongside a pop
  always_comb begin
    do_pop_s  = pop && (count_q != {CW{1'b0}});
    do_push_s = push && ((count_q != CW'(DEPTH)) || do_pop_s);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    if (clear) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = ptr_next(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_next(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_push_s && !do_pop_s) begin
        count_d = count_q + CW'(1);
      end else if (do_pop_s && !do_push_s) begin
        count_d = count_q - CW'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  // pointer/count registers and entry storage
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push_s && !clear) begin
        mem_q[wr_ptr_q] <= wdata;
      end
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue sharing one byte bus between core data accesses
// (highest priority) and sequential code fetch at cs:ip.
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        resetn,
  output logic [19:0] mem_address,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_out,
  output logic        mem_wren,
  output logic [7:0]  q_byte,
  output logic [15:0] q_ip,
  output logic        q_valid,
  input  logic        q_take,
  input  logic        flush,
  input  logic [15:0] flush_cs,
  input  logic [15:0] flush_ip,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [19:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_ack,
  output logic [7:0]  d_rdata
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   cs_q, cs_d;
  logic [15:0]   ip_q, ip_d;
  logic [15:0]   pend_ip_q, pend_ip_d;
  logic          fetch_pend_q, fetch_pend_d;
  logic          data_pend_q, data_pend_d;
  bus_owner_e    owner_s;
  logic [CW-1:0] fifo_count_s;
  logic [CW:0]   occupancy_s;
  logic [23:0]   fifo_head_s;
  logic [19:0]   fetch_addr_s;
  logic          fifo_empty_s, room_s, head_valid_s, take_s, push_s, pop_s;

  // bus arbitration: DATA > FETCH > IDLE, using registered count and inflight only
  always_comb begin
    fetch_addr_s = linear_addr(cs_q, ip_q);
    occupancy_s  = {1'b0, fifo_count_s} + {{CW{1'b0}}, fetch_pend_q};
    room_s       = (occupancy_s < (CW + 1)'(DEPTH));
    if (!resetn) begin
      owner_s = OWN_IDLE;
    end else if (d_req && !data_pend_q) begin
      owner_s = OWN_DATA;
    end else if (!flush && room_s) begin
      owner_s = OWN_FETCH;
    end else begin
      owner_s = OWN_IDLE;
    end
  end

  // bus drive; an idle bus shows the next fetch address with writes off
  always_comb begin
    mem_address = fetch_addr_s;
    mem_wren    = 1'b0;
    mem_out     = 8'h00;
    case (owner_s)
      OWN_DATA: begin
        mem_address = d_addr;
        mem_wren    = d_we;
        mem_out     = d_wdata;
      end
      OWN_FETCH: mem_address = fetch_addr_s;
      default:   mem_address = fetch_addr_s;
    endcase
  end

  // queue head with fall-through of a returning byte when the queue is empty
  always_comb begin
    fifo_empty_s = (fifo_count_s == {CW{1'b0}});
    head_valid_s = !fifo_empty_s || fetch_pend_q;
    if (fifo_empty_s) begin
      q_byte = mem_rdata;
      q_ip   = pend_ip_q;
    end else begin
      q_byte = fifo_head_s[7:0];
      q_ip   = fifo_head_s[23:8];
    end
    q_valid = head_valid_s;
    take_s  = q_take && head_valid_s && !flush;
    pop_s   = take_s && !fifo_empty_s;
    push_s  = fetch_pend_q && !flush && !(take_s && fifo_empty_s);
  end

  // next-state for fetch pointer, inflight tag and data handshake
  always_comb begin
    cs_d         = cs_q;
    ip_d         = ip_q;
    pend_ip_d    = pend_ip_q;
    fetch_pend_d = (owner_s == OWN_FETCH);
    data_pend_d  = (owner_s == OWN_DATA);
    if (flush) begin
      cs_d = flush_cs;
      ip_d = flush_ip;
    end else if (owner_s == OWN_FETCH) begin
      ip_d = ip_q + 16'd1;
    end else begin
      ip_d = ip_q;
    end
    if (owner_s == OWN_FETCH) begin
      pend_ip_d = ip_q;
    end else begin
      pend_ip_d = pend_ip_q;
    end
  end

  // control registers; reset abandons any outstanding access
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cs_q         <= RESET_CS;
      ip_q         <= RESET_IP;
      pend_ip_q    <= 16'h0000;
      fetch_pend_q <= 1'b0;
      data_pend_q  <= 1'b0;
    end else begin
      cs_q         <= cs_d;
      ip_q         <= ip_d;
      pend_ip_q    <= pend_ip_d;
      fetch_pend_q <= fetch_pend_d;
      data_pend_q  <= data_pend_d;
    end
  end

  assign d_ack   = data_pend_q;
  assign d_rdata = data_pend_q ? mem_rdata : 8'h00;

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push_s),
    .pop    (pop_s),
    .clear  (flush),
    .wdata  ({pend_ip_q, mem_rdata}),
    .rdata  (fifo_head_s),
    .count  (fifo_count_s)
  );

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: memory returns (addr[7:0] + A0) except
// for the single most recent write location.
module tb_prefetch_queue;

  logic        clock;
  logic        resetn;
  logic [19:0] mem_address;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_out;
  logic        mem_wren;
  logic [7:0]  q_byte;
  logic [15:0] q_ip;
  logic        q_valid;
  logic        q_take;
  logic        flush;
  logic [15:0] flush_cs;
  logic [15:0] flush_ip;
  logic        d_req;
  logic        d_we;
  logic [19:0] d_addr;
  logic [7:0]  d_wdata;
  logic        d_ack;
  logic [7:0]  d_rdata;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [19:0] wr_addr_r;
  logic [7:0]  wr_data_r;
  logic        wr_vld_r;

  prefetch_queue #(.DEPTH(6)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .mem_address (mem_address),
    .mem_rdata   (mem_rdata),
    .mem_out     (mem_out),
    .mem_wren    (mem_wren),
    .q_byte      (q_byte),
    .q_ip        (q_ip),
    .q_valid     (q_valid),
    .q_take      (q_take),
    .flush       (flush),
    .flush_cs    (flush_cs),
    .flush_ip    (flush_ip),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_ack       (d_ack),
    .d_rdata     (d_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_read(input logic [19:0] a);
    if (wr_vld_r && (a == wr_addr_r)) begin
      return wr_data_r;
    end else begin
      return a[7:0] + 8'hA0;
    end
  endfunction

  // memory model: read data one cycle after address, last write remembered
  always @(posedge clock) begin
    mem_rdata <= mem_read(mem_address);
    if (mem_wren) begin
      wr_vld_r  <= 1'b1;
      wr_addr_r <= mem_address;
      wr_data_r <= mem_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wr_vld_r  = 1'b0;
    wr_addr_r = 20'h00000;
    wr_data_r = 8'h00;
    resetn    = 1'b0;
    q_take    = 1'b0;
    flush     = 1'b0;
    flush_cs  = 16'h0000;
    flush_ip  = 16'h0000;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 20'h00000;
    d_wdata   = 8'h00;
    cyc();
    cyc();
    mid();
    chk("rst_addr",  mem_address, 32'h000FFFF0);
    chk("rst_qv",    q_valid,     32'd0);
    chk("rst_ack",   d_ack,       32'd0);
    chk("rst_wren",  mem_wren,    32'd0);
    chk("rst_mout",  mem_out,     32'd0);
    cyc();
    resetn = 1'b1;

    // six back-to-back fetches after reset release
    for (int k = 0; k < 6; k++) begin
      mid();
      chk("boot_addr", mem_address, 32'h000FFFF0 + 32'(k));
      chk("boot_wren", mem_wren, 32'd0);
      if (k == 1) begin
        chk("boot_qv",   q_valid, 32'd1);
        chk("boot_byte", q_byte,  32'h90);
        chk("boot_ip",   q_ip,    32'h0000);
      end
      cyc();
    end
    for (int k = 0; k < 4; k++) cyc();
    mid();
    chk("full_qv",   q_valid, 32'd1);
    chk("full_byte", q_byte,  32'h90);
    chk("full_ip",   q_ip,    32'h0000);
    cyc();

    // drain with take held: in-order bytes, fetches resume one cycle later
    q_take = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mid();
      chk("drain_byte", q_byte, 32'h90 + 32'(i));
      chk("drain_ip",   q_ip,   32'(i));
      if (i >= 1 && i <= 3) begin
        chk("drain_addr", mem_address, 32'h000FFFF6 + 32'(i - 1));
      end
      cyc();
    end

    // data read during streaming
    d_req = 1'b1; d_we = 1'b0; d_addr = 20'h12345;
    mid();
    chk("rd_addr", mem_address, 32'h00012345);
    chk("rd_wren", mem_wren,    32'd0);
    chk("rd_ack0", d_ack,       32'd0);
    cyc();
    mid();
    chk("rd_ack1",  d_ack,       32'd1);
    chk("rd_data",  d_rdata,     32'hE5);
    chk("rd_fetch", mem_address, 32'h000FFFFD);
    chk("rd_qip",   q_ip,        32'h0009);
    cyc();
    d_req = 1'b0;
    mid();
    chk("rd_ack2", d_ack, 32'd0);
    cyc();

    // data write
    d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00400; d_wdata = 8'hAA;
    mid();
    chk("wr_wren", mem_wren,    32'd1);
    chk("wr_addr", mem_address, 32'h00000400);
    chk("wr_mout", mem_out,     32'hAA);
    cyc();
    mid();
    chk("wr_wren1", mem_wren, 32'd0);
    chk("wr_ack1",  d_ack,    32'd1);
    cyc();
    d_req = 1'b0; d_we = 1'b0;
    mid();
    chk("wr_ack2", d_ack, 32'd0);
    cyc();
    cyc();

    // flush to 1234:FFFF with a fetch in flight
    flush = 1'b1; flush_cs = 16'h1234; flush_ip = 16'hFFFF;
    cyc();
    flush = 1'b0;
    mid();
    chk("fl_qv1",   q_valid,     32'd0);
    chk("fl_addr1", mem_address, 32'h0002233F);
    cyc();
    mid();
    chk("fl_qv2",   q_valid,     32'd1);
    chk("fl_ip2",   q_ip,        32'h0000FFFF);
    chk("fl_byte2", q_byte,      32'hDF);
    chk("fl_addr2", mem_address, 32'h00012340);
    cyc();
    mid();
    chk("fl_ip3",   q_ip,   32'h0000);
    chk("fl_byte3", q_byte, 32'hE0);
    cyc();
    q_take = 1'b0;
    for (int k = 0; k < 8; k++) cyc();

    // flush + take + data read in one cycle
    flush = 1'b1; flush_cs = 16'h2000; flush_ip = 16'h0010;
    q_take = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 20'h00400;
    mid();
    chk("ft_addr", mem_address, 32'h00000400);
    chk("ft_qv0",  q_valid,     32'd1);
    cyc();
    flush = 1'b0; q_take = 1'b0;
    mid();
    chk("ft_ack",   d_ack,       32'd1);
    chk("ft_data",  d_rdata,     32'hAA);
    chk("ft_qv1",   q_valid,     32'd0);
    chk("ft_fetch", mem_address, 32'h00020010);
    cyc();
    d_req = 1'b0;
    mid();
    chk("ft_qv2",   q_valid, 32'd1);
    chk("ft_ip2",   q_ip,    32'h0010);
    chk("ft_byte2", q_byte,  32'hB0);
    chk("ft_ack2",  d_ack,   32'd0);
    cyc();

    // reset with a write request pending
    resetn = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00123; d_wdata = 8'h55;
    mid();
    chk("mr_wren", mem_wren, 32'd0);
    cyc();
    d_req = 1'b0; d_we = 1'b0;
    mid();
    chk("mr_ack", d_ack,   32'd0);
    chk("mr_qv",  q_valid, 32'd0);
    cyc();
    resetn = 1'b1;
    mid();
    chk("mr_addr", mem_address, 32'h000FFFF0);
    cyc();
    mid();
    chk("mr_qv1",  q_valid, 32'd1);
    chk("mr_byte", q_byte,  32'h90);
    chk("mr_ip",   q_ip,    32'h0000);
    cyc();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
